// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use detection,
// branch squash, and scheduling of the shared multi-cycle mult/div unit.
module pipeline_hazard_controller #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             id_md_start,
    input  logic             id_md_is_div,
    input  logic             id_reads_hilo,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_is_div,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [LAT_W-1:0] cnt, cnt_nx;
    logic             is_div_nx;
    logic             lu, ms, stall, accept;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependence.
    assign lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign ms     = (state == BUSY) && (id_md_start || id_reads_hilo);
    assign stall  = lu || ms;
    assign accept = id_md_start && !stall && (state != BUSY);

    // Combinational controls are forced low while reset is held so the pipeline sees a clean idle.
    assign pc_hold     = stall && !reset;
    assign ifid_hold   = stall && !reset;
    assign idex_bubble = stall && !reset;
    assign ifid_flush  = branch_taken && !stall && !reset;
    assign md_busy     = (state == BUSY);
    assign md_done     = (state == DONE);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_nx  = state;
        cnt_nx    = cnt;
        is_div_nx = md_is_div;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx  = BUSY;
                    cnt_nx    = id_md_is_div ? LAT_W'(DIV_LAT) : LAT_W'(MUL_LAT);
                    is_div_nx = id_md_is_div;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (cnt == LAT_W'(1)) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - LAT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            md_is_div <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            md_is_div <= is_div_nx;
        end
    end

    // Saturating performance counter: holds at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pc_hold && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared against a
// timestamp-based model of the mult/div unit and the hazard rules.
module tb_pipeline_hazard_controller;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 12;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, branch_taken;
    logic             id_md_start, id_md_is_div, id_reads_hilo;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble;
    logic             md_busy, md_done, md_is_div;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .id_md_start  (id_md_start),
        .id_md_is_div (id_md_is_div),
        .id_reads_hilo(id_reads_hilo),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_is_div    (md_is_div),
        .stall_cycles (stall_cycles)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the current operation is described by its start cycle and latency.
    int cyc      = 0;
    bit op_valid = 1'b0;
    int op_e     = 0;
    int op_lat   = 0;
    bit op_div   = 1'b0;
    int sc       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit busy_at(input int c);
        return op_valid && (c >= op_e) && (c < op_e + op_lat);
    endfunction

    function automatic bit done_at(input int c);
        return op_valid && (c == op_e + op_lat);
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] ert, input logic bt,
                         input logic st, input logic dv, input logic hl);
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rt    = urt;
        ex_memread    = mr;
        ex_rt         = ert;
        branch_taken  = bt;
        id_md_start   = st;
        id_md_is_div  = dv;
        id_reads_hilo = hl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_hold"},      32'(pc_hold),      32'd0);
        check({tag, "_ifid_hold"},    32'(ifid_hold),    32'd0);
        check({tag, "_ifid_flush"},   32'(ifid_flush),   32'd0);
        check({tag, "_idex_bubble"},  32'(idex_bubble),  32'd0);
        check({tag, "_md_busy"},      32'(md_busy),      32'd0);
        check({tag, "_md_done"},      32'(md_done),      32'd0);
        check({tag, "_md_is_div"},    32'(md_is_div),    32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd0);
    endtask

    // One pipeline cycle: apply inputs after negedge, compare, then advance the model at posedge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic bt,
                        input logic st, input logic dv, input logic hl, output bit acc);
        bit lu_m, ms_m, stall_m;
        @(negedge clk);
        drive(rs, rt, urt, mr, ert, bt, st, dv, hl);
        #1;
        lu_m    = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        ms_m    = busy_at(cyc) && (st || hl);
        stall_m = lu_m || ms_m;
        acc     = st && !stall_m && !busy_at(cyc);
        check("pc_hold",      32'(pc_hold),      32'(stall_m));
        check("ifid_hold",    32'(ifid_hold),    32'(stall_m));
        check("idex_bubble",  32'(idex_bubble),  32'(stall_m));
        check("ifid_flush",   32'(ifid_flush),   32'(bt && !stall_m));
        check("md_busy",      32'(md_busy),      32'(busy_at(cyc)));
        check("md_done",      32'(md_done),      32'(done_at(cyc)));
        check("md_is_div",    32'(md_is_div),    32'(op_div));
        check("stall_cycles", 32'(stall_cycles), 32'(sc));
        @(posedge clk);
        if (stall_m && sc < SAT) sc++;
        if (acc) begin
            op_valid = 1'b1;
            op_e     = cyc + 1;
            op_lat   = dv ? DIV_LAT : MUL_LAT;
            op_div   = dv;
        end
        cyc++;
    endtask

    task automatic quiet(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    // Called just after a posedge: asserts reset between edges with hazard-causing inputs present.
    task automatic async_reset(input int hold_edges);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        #3 reset = 1'b1;
        #1 check_all_zero("rst");
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        op_valid = 1'b0;
        op_div   = 1'b0;
        sc       = 0;
    endtask

    initial begin
        bit acc;
        bit got;
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_all_zero("init");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Load-use on rs, then the same with register 0.
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        // rt dependence only counts when rt is a source.
        step(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        // Branch flush, and a branch suppressed by a stall.
        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, acc);

        // Multiply followed by mfhi held until the unit finishes.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        check("mul_accepted", 32'(acc), 32'd1);
        quiet(1);
        for (int i = 0; i < 5; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        quiet(2);

        // Back-to-back: divide presented while a multiply is busy.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
            got = acc;
        end
        check("div_accepted_in_done", 32'(got), 32'd1);
        quiet(DIV_LAT + 2);

        // Reset in the middle of a divide (count down to 6), then no done pulse afterwards.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        quiet(6);
        async_reset(2);
        quiet(DIV_LAT + 4);

        // Counter saturation with a narrow counter.
        for (int i = 0; i < SAT + 5; i++)
            step(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        quiet(1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
            end else begin
                step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                     5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) == 0), acc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
